seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//   All digits share one BCD/hex-to-segment decoder.

---
 rtl/seg_scan_ctrl_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Load port for seg_scan_ctrl: a packed nibble-per-digit value offered over valid/ready.
interface seg_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 4
) ();

  logic [4*N_DIGITS-1:0] Value;
  logic                  Load_valid;
  logic                  Load_ready;

  modport master (
    output Value,
    output Load_valid,
    input  Load_ready
  );

  modport slave (
    input  Value,
    input  Load_valid,
    output Load_ready
  );

endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Walks the digits GAP -> SHOW per slot, drives one anode at a time and presents the
// lit digit's nibble to a shared decoder. New values are double-buffered and only
// committed at frame boundaries (or while idle), so a frame is never torn.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DWELL    = 1000,
  parameter int unsigned BLANK    = 16,
  parameter bit          LZB_EN   = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic [N_DIGITS-1:0] Dp_mask,
  seg_scan_ctrl_if.slave      load,
  output logic [3:0]          Seg_code,
  output logic                Seg_dp_n,
  output logic [N_DIGITS-1:0] Anode_n,
  output logic                Frame_tick
);

  localparam int unsigned CntMax = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = $clog2(N_DIGITS);
  localparam int unsigned DataW  = 4 * N_DIGITS;

  localparam logic [CntW-1:0] ShowLast = CntW'(DWELL - 1);
  // Gap is never entered when BLANK is 0, so the clamp only keeps the constant legal.
  localparam logic [CntW-1:0] GapLast  = CntW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StShow
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [DataW-1:0]   disp_q, disp_d;
  logic [DataW-1:0]   shadow_q;
  logic               pending_q, pending_d;
  logic               frame_end;
  logic               xfer;
  logic               commit;

  logic [N_DIGITS-1:0] lead_zero;
  logic                all_zero;
  logic [3:0]          nib;
  logic                blanked;

  logic [N_DIGITS-1:0] anode_d;
  logic [3:0]          code_d;
  logic                dp_n_d;

  // Scan sequencing: slot counter, digit index and frame-end detection.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    if (!Enable) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = (BLANK == 0) ? StShow : StGap;
          idx_d   = '0;
          cnt_d   = '0;
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = (BLANK == 0) ? StShow : StGap;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Load buffering: accept into shadow, commit to display at frame end or while idle.
  always_comb begin
    xfer      = load.Load_valid & ~pending_q;
    commit    = pending_q & (frame_end | (state_q == StIdle));
    pending_d = pending_q;
    disp_d    = disp_q;
    if (xfer) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
      disp_d    = shadow_q;
    end
  end

  assign load.Load_ready = ~pending_q;

  // Leading-zero map: lead_zero[i] is set when digits N-1 down to i are all zero.
  always_comb begin
    lead_zero = '0;
    all_zero  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (disp_d[4*i +: 4] == 4'h0);
      lead_zero[i] = all_zero;
    end
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    nib     = disp_d[{idx_d, 2'b00} +: 4];
    blanked = LZB_EN && (idx_d != '0) && lead_zero[idx_d];
    anode_d = '1;
    code_d  = 4'h0;
    dp_n_d  = 1'b1;
    unique case (state_d)
      StGap: begin
        code_d = nib;
      end
      StShow: begin
        code_d = nib;
        if (!blanked) begin
          anode_d[idx_d] = 1'b0;
          dp_n_d         = ~Dp_mask[idx_d];
        end
      end
      default: begin
        code_d = 4'h0;
      end
    endcase
  end

  // State, buffers and registered outputs; reset blanks the display immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      Anode_n    <= '1;
      Seg_code   <= 4'h0;
      Seg_dp_n   <= 1'b1;
      Frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      pending_q  <= pending_d;
      if (xfer) begin
        shadow_q <= load.Value;
      end
      Anode_n    <= anode_d;
      Seg_code   <= code_d;
      Seg_dp_n   <= dp_n_d;
      Frame_tick <= frame_end;
    end
  end

endmodule
